// File: rtl/cmd_frame_decoder_pkg.sv
// Shared definitions for the host command frame decoder:
// command bytes, operand register addresses and FSM state encoding.
package cmd_frame_decoder_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned REG_OP_A = 0;
    localparam int unsigned REG_OP_B = 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_LO    = 4'd9,
        ST_TX_HI    = 4'd10
    } state_t;

endpackage

// File: rtl/cmd_frame_decoder.sv
// Decodes host command frames from the UART RX byte stream, drives the
// register file and ALU, and pushes response bytes into the TX FIFO.
module cmd_frame_decoder
    import cmd_frame_decoder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_FUN_WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic [ADDR_WIDTH-1:0]    rf_addr,
    output logic                     rf_wr_en,
    output logic [DATA_WIDTH-1:0]    rf_wr_data,
    output logic                     rf_rd_en,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data,
    input  logic                     rf_rd_valid,
    output logic                     alu_en,
    output logic [ALU_FUN_WIDTH-1:0] alu_fun,
    output logic                     alu_clk_en,
    input  logic [2*DATA_WIDTH-1:0]  alu_out,
    input  logic                     alu_out_valid,
    output logic [DATA_WIDTH-1:0]    fifo_wr_data,
    output logic                     fifo_wr_inc,
    input  logic                     fifo_full
);

    state_t                state;
    logic [DATA_WIDTH-1:0] resp_hi;
    logic                  resp_is_alu;

    // A push is issued the cycle after fifo_full is seen low; while in TX_LO/TX_HI
    // a high fifo_wr_inc means the current byte is being pushed right now.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            rf_addr      <= '0;
            rf_wr_en     <= 1'b0;
            rf_wr_data   <= '0;
            rf_rd_en     <= 1'b0;
            alu_en       <= 1'b0;
            alu_fun      <= '0;
            alu_clk_en   <= 1'b0;
            fifo_wr_data <= '0;
            fifo_wr_inc  <= 1'b0;
            resp_hi      <= '0;
            resp_is_alu  <= 1'b0;
        end else begin
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            alu_en      <= 1'b0;
            fifo_wr_inc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == DATA_WIDTH'(CMD_RF_WR)) begin
                            state <= ST_WR_ADDR;
                        end else if (rx_data == DATA_WIDTH'(CMD_RF_RD)) begin
                            state <= ST_RD_ADDR;
                        end else if (rx_data == DATA_WIDTH'(CMD_ALU_OP)) begin
                            state <= ST_OP_A;
                        end else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) begin
                            state      <= ST_ALU_FUN;
                            alu_clk_en <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (rx_valid) begin
                        rf_addr <= rx_data[ADDR_WIDTH-1:0];
                        state   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_valid) begin
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (rx_valid) begin
                        rf_addr  <= rx_data[ADDR_WIDTH-1:0];
                        rf_rd_en <= 1'b1;
                        state    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rf_rd_valid) begin
                        fifo_wr_data <= rf_rd_data;
                        fifo_wr_inc  <= !fifo_full;
                        resp_is_alu  <= 1'b0;
                        state        <= ST_TX_LO;
                    end
                end
                ST_OP_A: begin
                    if (rx_valid) begin
                        rf_addr    <= ADDR_WIDTH'(REG_OP_A);
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= ST_OP_B;
                    end
                end
                ST_OP_B: begin
                    if (rx_valid) begin
                        rf_addr    <= ADDR_WIDTH'(REG_OP_B);
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        alu_clk_en <= 1'b1;
                        state      <= ST_ALU_FUN;
                    end
                end
                ST_ALU_FUN: begin
                    if (rx_valid) begin
                        alu_fun <= rx_data[ALU_FUN_WIDTH-1:0];
                        alu_en  <= 1'b1;
                        state   <= ST_ALU_WAIT;
                    end
                end
                ST_ALU_WAIT: begin
                    if (alu_out_valid) begin
                        fifo_wr_data <= alu_out[DATA_WIDTH-1:0];
                        resp_hi      <= alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
                        fifo_wr_inc  <= !fifo_full;
                        resp_is_alu  <= 1'b1;
                        alu_clk_en   <= 1'b0;
                        state        <= ST_TX_LO;
                    end
                end
                ST_TX_LO: begin
                    if (fifo_wr_inc) begin
                        if (resp_is_alu) begin
                            fifo_wr_data <= resp_hi;
                            fifo_wr_inc  <= !fifo_full;
                            state        <= ST_TX_HI;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        fifo_wr_inc <= !fifo_full;
                    end
                end
                ST_TX_HI: begin
                    if (fifo_wr_inc) begin
                        state <= ST_IDLE;
                    end else begin
                        fifo_wr_inc <= !fifo_full;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
